// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared types and width helpers for the 512-bit FIFO packer
package fifo_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PUSH = 1'b1
  } state_t;

  function automatic int ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic bit widths_ok(input int in_w, input int out_w);
    return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0);
  endfunction

endpackage

// File: rtl/fifo_pack_512.sv
// rtl/fifo_pack_512.sv - packs narrow valid/ready words into wide lines for simple_fifo_512
module fifo_pack_512
  import fifo_pack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 512,
  localparam int RATIO    = ratio(IN_WIDTH, OUT_WIDTH),
  localparam int IDX_W    = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 fifo_we,
  output logic [OUT_WIDTH-1:0] fifo_din,
  input  logic                 fifo_full,
  output logic [IDX_W-1:0]     line_words,
  output logic [31:0]          lines_written
);

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_width_check
    $error("fifo_pack_512: OUT_WIDTH must be a multiple of IN_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OUT_WIDTH-1:0]   line_q, line_d;
  logic [31:0]            cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    fifo_we  = 1'b0;

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Lane decoder: idx selects which IN_WIDTH slice takes the word.
          for (int i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
              line_d[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(RATIO - 1) || in_last) begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        if (!fifo_full) begin
          fifo_we = 1'b1;
          state_d = FILL;
          idx_d   = '0;
          line_d  = '0;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      default: state_d = FILL;
    endcase

    // Handshake outputs are gated so nothing escapes while reset is held.
    if (reset) begin
      in_ready = 1'b0;
      fifo_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_din      = line_q;
  assign line_words    = idx_q;
  assign lines_written = cnt_q;

endmodule

// File: tb/tb_fifo_pack_512.sv
// tb/tb_fifo_pack_512.sv - randomized scoreboard bench for fifo_pack_512
module tb_fifo_pack_512;

  localparam int IW = 32;
  localparam int OW = 512;
  localparam int R  = OW / IW;
  localparam int IX = $clog2(R) + 1;

  typedef struct {
    logic [OW-1:0] line;
    int            words;
    logic [31:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          fifo_we;
  logic [OW-1:0] fifo_din;
  logic          fifo_full;
  logic [IX-1:0] line_words;
  logic [31:0]   lines_written;

  fifo_pack_512 #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .fifo_we      (fifo_we),
    .fifo_din     (fifo_din),
    .fifo_full    (fifo_full),
    .line_words   (line_words),
    .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  exp_t          sb[$];
  logic [IW-1:0] cur[$];
  logic [31:0]   exp_cnt = 0;
  bit            full_rand = 0;
  logic          full_val = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the oldest closed reference line.
  always @(negedge clk) begin
    if (fifo_full === 1'b1) chk("we_gated_by_full", {511'b0, fifo_we}, '0);
    if (fifo_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("din", fifo_din, e.line);
        chk("line_words", OW'(line_words), OW'(e.words));
        chk("lines_written_at_write", OW'(lines_written), OW'(e.cnt));
      end
    end
  end

  // Reference model: words collect into a list; a line closes at R words or on last.
  task automatic model_accept(input logic [IW-1:0] d, input logic l);
    exp_t e;
    cur.push_back(d);
    if (cur.size() == R || l) begin
      e.line = '0;
      for (int i = 0; i < cur.size(); i++) e.line[i*IW +: IW] = cur[i];
      e.words = cur.size();
      e.cnt   = exp_cnt;
      sb.push_back(e);
      exp_cnt = exp_cnt + 32'd1;
      cur.delete();
    end
  endtask

  task automatic step(input logic v, input logic [IW-1:0] d, input logic l, output logic acc);
    in_valid  = v;
    in_data   = v ? d : IW'($urandom);
    in_last   = v ? l : 1'($urandom);
    fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : full_val;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
    if (acc) model_accept(d, l);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic l, input bit gap);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    if (gap) idle(1);
    while (!a && n < 300) begin
      step(1'b1, d, l, a);
      n++;
    end
    if (!a) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    full_rand = 0;
    full_val  = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_timeout", OW'(sb.size()), '0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ready_in_reset", {511'b0, in_ready}, '0);
      chk("we_in_reset", {511'b0, fifo_we}, '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    cur.delete();
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("ready_after_reset", {511'b0, in_ready}, 1);
    chk("cnt_after_reset", OW'(lines_written), '0);
    chk("words_after_reset", OW'(line_words), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full line, in_valid held; the write must appear right after the last accept.
    for (int i = 0; i < R; i++) send_word(IW'(i), 1'b0, 0);
    @(negedge clk);
    chk("full_line_latency", {511'b0, fifo_we}, 1);
    chk("full_line_words", OW'(line_words), OW'(R));
    chk("full_line_lane15", OW'(fifo_din[511:480]), OW'(32'hF));
    @(posedge clk);
    #1;
    chk("full_line_cnt", OW'(lines_written), OW'(1));

    // Partial line closed by in_last.
    send_word(32'hA, 1'b0, 0);
    send_word(32'hB, 1'b0, 0);
    send_word(32'hC, 1'b1, 0);
    @(negedge clk);
    chk("partial_words", OW'(line_words), OW'(3));
    chk("partial_upper_zero", OW'(fifo_din[511:96]), '0);
    @(posedge clk);
    #1;

    // Backpressure held for 5 cycles after the line completes.
    full_val = 1'b1;
    for (int i = 0; i < R; i++) send_word(IW'($urandom), 1'b0, 0);
    held = fifo_din;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_we", {511'b0, fifo_we}, '0);
      chk("bp_ready", {511'b0, in_ready}, '0);
      chk("bp_din_stable", fifo_din, held);
      @(posedge clk);
      #1;
    end
    full_val  = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_release_we", {511'b0, fifo_we}, 1);
    @(posedge clk);
    #1;

    // Reset mid-line discards the 7 words already taken.
    for (int i = 0; i < 7; i++) send_word(32'hDEAD0000 | IW'(i), 1'b0, 0);
    do_reset();
    for (int i = 0; i < R; i++) send_word(32'h5A000000 | IW'(i), 1'b0, 0);
    drain();
    idle(1);
    chk("midreset_cnt", OW'(lines_written), OW'(1));

    // Reset while a line waits in PUSH behind a full FIFO.
    full_val = 1'b1;
    for (int i = 0; i < 5; i++) send_word(IW'($urandom), (i == 4), 0);
    @(negedge clk);
    chk("push_full_no_we", {511'b0, fifo_we}, '0);
    @(posedge clk);
    #1;
    do_reset();
    full_val = 1'b0;

    // Counter wrap with every-other-cycle valid.
    force dut.cnt_q = 32'hFFFF_FFFF;
    idle(2);
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    idle(1);
    chk("wrap_preload", OW'(lines_written), OW'(32'hFFFF_FFFF));
    for (int i = 0; i < R; i++) send_word(IW'($urandom), 1'b0, 1);
    drain();
    idle(1);
    chk("wrap_cnt", OW'(lines_written), '0);

    // Randomized traffic: random data, last, gaps and backpressure.
    full_rand = 1;
    for (int i = 0; i < 400; i++) begin
      send_word(IW'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end
    send_word(IW'($urandom), 1'b1, 0);
    drain();
    idle(1);
    chk("final_cnt", OW'(lines_written), OW'(exp_cnt));
    chk("final_words", OW'(line_words), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
